// File: rtl/mdu_issue_sched_if.sv
// Dispatch <-> MDU issue scheduler bundle: enqueue side, issue side and status.
// master = dispatch/test driver, slave = mdu_issue_sched.
interface mdu_issue_sched_if #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 6,
  parameter int PRF_W = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic             enq_is_div;
  logic             enq_signed;
  logic [ID_W-1:0]  enq_id;
  logic [PRF_W-1:0] enq_hi_prf;
  logic [PRF_W-1:0] enq_lo_prf;
  logic             iss_valid;
  logic             iss_is_div;
  logic             iss_signed;
  logic [ID_W-1:0]  iss_id;
  logic [PRF_W-1:0] iss_hi_prf;
  logic [PRF_W-1:0] iss_lo_prf;
  logic             wb_slot_busy;
  logic [CNT_W-1:0] count;
  logic             idle;

  modport master (
    output flush, enq_valid, enq_is_div, enq_signed, enq_id, enq_hi_prf, enq_lo_prf,
    input  enq_ready, iss_valid, iss_is_div, iss_signed, iss_id, iss_hi_prf, iss_lo_prf,
    input  wb_slot_busy, count, idle
  );

  modport slave (
    input  flush, enq_valid, enq_is_div, enq_signed, enq_id, enq_hi_prf, enq_lo_prf,
    output enq_ready, iss_valid, iss_is_div, iss_signed, iss_id, iss_hi_prf, iss_lo_prf,
    output wb_slot_busy, count, idle
  );
endinterface

// File: rtl/mdu_issue_sched.sv
// In-order MDU issue scheduler: FIFO of ops, issues the head only when its Hi/Lo writeback slots are free.
// Enq-to-issue >= 1 cycle; MDU_ISSUE_BYPASS_EN enables 0-cycle issue from an empty FIFO. enq_ready = not full.
module mdu_issue_sched #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 20,
  parameter int ID_W    = 6,
  parameter int PRF_W   = 6
) (
  input  logic           clk,
  input  logic           rst,
  mdu_issue_sched_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RESV_W = DIV_LAT + 2;

  typedef struct packed {
    logic             is_div;
    logic             sgn;
    logic [ID_W-1:0]  id;
    logic [PRF_W-1:0] hi_prf;
    logic [PRF_W-1:0] lo_prf;
  } op_t;

  op_t              mem_q [DEPTH];
  op_t              mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RESV_W-1:0] resv_q, resv_d;

  op_t  enq_op, head_op, iss_op, iss_out;
  logic head_vld, head_conf, head_iss, byp_iss, iss, enq_rdy, enq_acc;

  assign enq_op   = '{is_div: bus.enq_is_div, sgn: bus.enq_signed, id: bus.enq_id,
                      hi_prf: bus.enq_hi_prf, lo_prf: bus.enq_lo_prf};
  assign head_op  = mem_q[rd_ptr_q];
  assign head_vld = (count_q != '0);
  assign enq_rdy  = (count_q < CNT_W'(DEPTH));

  // An op needs both its Hi slot (L) and Lo slot (L+1) free.
  assign head_conf = head_op.is_div ? (resv_q[DIV_LAT] | resv_q[DIV_LAT+1])
                                    : (resv_q[MUL_LAT] | resv_q[MUL_LAT+1]);
  assign head_iss  = head_vld & !head_conf & !bus.flush;

`ifdef MDU_ISSUE_BYPASS_EN
  logic enq_conf;
  assign enq_conf = bus.enq_is_div ? (resv_q[DIV_LAT] | resv_q[DIV_LAT+1])
                                   : (resv_q[MUL_LAT] | resv_q[MUL_LAT+1]);
  assign byp_iss  = !head_vld & bus.enq_valid & !bus.flush & !enq_conf;
`else
  assign byp_iss  = 1'b0;
`endif

  assign iss     = head_iss | byp_iss;
  assign iss_op  = byp_iss ? enq_op : head_op;
  assign iss_out = iss ? iss_op : '0;
  assign enq_acc = bus.enq_valid & enq_rdy & !bus.flush & !byp_iss;

  always_comb begin
    mem_d = mem_q;
    if (enq_acc) mem_d[wr_ptr_q] = enq_op;

    wr_ptr_d = wr_ptr_q + PTR_W'(enq_acc);
    rd_ptr_d = bus.flush ? wr_ptr_q : (rd_ptr_q + PTR_W'(head_iss));
    count_d  = bus.flush ? '0 : (count_q + CNT_W'(enq_acc) - CNT_W'(head_iss));

    // Reservations shift toward slot 0; an issue claims L and L+1, seen one cycle later as L-1 and L.
    resv_d = {1'b0, resv_q[RESV_W-1:1]};
    if (iss) begin
      if (iss_op.is_div) begin
        resv_d[DIV_LAT-1] = 1'b1;
        resv_d[DIV_LAT]   = 1'b1;
      end else begin
        resv_d[MUL_LAT-1] = 1'b1;
        resv_d[MUL_LAT]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      resv_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      resv_q   <= resv_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.enq_ready    = enq_rdy;
  assign bus.iss_valid    = iss;
  assign bus.iss_is_div   = iss_out.is_div;
  assign bus.iss_signed   = iss_out.sgn;
  assign bus.iss_id       = iss_out.id;
  assign bus.iss_hi_prf   = iss_out.hi_prf;
  assign bus.iss_lo_prf   = iss_out.lo_prf;
  assign bus.wb_slot_busy = resv_q[0];
  assign bus.count        = count_q;
  assign bus.idle         = (count_q == '0) & (resv_q == '0);
endmodule

// File: tb/tb_mdu_issue_sched.sv
// Bench for mdu_issue_sched: absolute-cycle writeback booking model checked every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_mdu_issue_sched;
  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 20;
  localparam int ID_W    = 6;
  localparam int PRF_W   = 6;
  localparam int BK      = 1024;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  mdu_issue_sched_if #(.DEPTH(DEPTH), .ID_W(ID_W), .PRF_W(PRF_W)) bus ();

  mdu_issue_sched #(
    .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ID_W(ID_W), .PRF_W(PRF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: queue of pending ops and a map of absolute cycles whose writeback port is taken.
  typedef struct {
    bit             is_div;
    bit             sgn;
    bit [ID_W-1:0]  id;
    bit [PRF_W-1:0] hi;
    bit [PRF_W-1:0] lo;
  } m_op_t;

  m_op_t       mq[$];
  bit          booked [BK];
  int          mcyc;
  m_op_t       m_op, m_enq;
  int          m_lat, m_sz;
  bit          e_iss, e_byp, e_any, m_acc;
  logic [31:0] e_bun, a_bun;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < BK; i++) booked[i] = 1'b0;
      mcyc = 0;
    end else begin
      m_sz  = mq.size();
      m_enq = '{is_div: bus.enq_is_div, sgn: bus.enq_signed, id: bus.enq_id,
                hi: bus.enq_hi_prf, lo: bus.enq_lo_prf};
      e_iss = 1'b0;
      e_byp = 1'b0;
      m_lat = 0;
      m_op  = m_enq;
      if (!bus.flush && m_sz > 0) begin
        m_op  = mq[0];
        m_lat = m_op.is_div ? DIV_LAT : MUL_LAT;
        e_iss = !booked[mcyc+m_lat] && !booked[mcyc+m_lat+1];
      end
`ifdef MDU_ISSUE_BYPASS_EN
      else if (!bus.flush && m_sz == 0 && bus.enq_valid) begin
        m_lat = m_enq.is_div ? DIV_LAT : MUL_LAT;
        e_iss = !booked[mcyc+m_lat] && !booked[mcyc+m_lat+1];
        e_byp = e_iss;
      end
`endif
      e_bun = e_iss ? 32'({1'b1, m_op.is_div, m_op.sgn, m_op.id, m_op.hi, m_op.lo}) : 32'd0;
      a_bun = 32'({bus.iss_valid, bus.iss_is_div, bus.iss_signed, bus.iss_id,
                   bus.iss_hi_prf, bus.iss_lo_prf});
      e_any = 1'b0;
      for (int j = 0; j <= DIV_LAT + 1; j++) e_any |= booked[mcyc+j];

      chk("m_issue", a_bun, e_bun);
      chk("m_enq_ready", 32'(bus.enq_ready), 32'(m_sz < DEPTH));
      chk("m_count", 32'(bus.count), 32'(m_sz));
      chk("m_wb_busy", 32'(bus.wb_slot_busy), 32'(booked[mcyc]));
      chk("m_idle", 32'(bus.idle), 32'(m_sz == 0 && !e_any));

      m_acc = bus.enq_valid && !bus.flush && (m_sz < DEPTH) && !e_byp;
      if (e_iss) begin
        booked[mcyc+m_lat]   = 1'b1;
        booked[mcyc+m_lat+1] = 1'b1;
        if (!e_byp) void'(mq.pop_front());
      end
      if (bus.flush) mq.delete();
      else if (m_acc) mq.push_back(m_enq);
      mcyc++;
    end
  end

  task automatic drive(input bit v, input bit div, input bit sgn, input int id, input bit fl);
    bus.enq_valid  = v;
    bus.enq_is_div = div;
    bus.enq_signed = sgn;
    bus.enq_id     = ID_W'(id);
    bus.enq_hi_prf = PRF_W'(id + 1);
    bus.enq_lo_prf = PRF_W'(id + 2);
    bus.flush      = fl;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    #1;
    chk({nm, "_count"}, 32'(bus.count), 32'd0);
    chk({nm, "_ready"}, 32'(bus.enq_ready), 32'd1);
    chk({nm, "_iss"}, 32'(bus.iss_valid), 32'd0);
    chk({nm, "_busy"}, 32'(bus.wb_slot_busy), 32'd0);
    chk({nm, "_idle"}, 32'(bus.idle), 32'd1);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_in();

    // Single multiply
    do_reset();
    check_reset("rst0");
    for (int k = 0; k < 8; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 1'b0, 5, 1'b0); else idle_in();
      #1;
`ifndef MDU_ISSUE_BYPASS_EN
      chk("t1_iss", 32'(bus.iss_valid), 32'(k == 1));
      chk("t1_busy", 32'(bus.wb_slot_busy), 32'(k == 4 || k == 5));
      if (k == 1) chk("t1_id", 32'(bus.iss_id), 32'd5);
      if (k >= 5) chk("t1_idle", 32'(bus.idle), 32'(k >= 6));
`endif
      next_cyc();
    end

    // Back-to-back multiplies
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 1'b0, 1, 1'b0);
      else if (k == 1) drive(1'b1, 1'b0, 1'b1, 2, 1'b0);
      else idle_in();
      #1;
`ifndef MDU_ISSUE_BYPASS_EN
      chk("t2_iss", 32'(bus.iss_valid), 32'(k == 1 || k == 3));
      if (k == 3) chk("t2_id", 32'(bus.iss_id), 32'd2);
      chk("t2_busy", 32'(bus.wb_slot_busy), 32'(k >= 4 && k <= 7));
`endif
      next_cyc();
    end

    // Divide then multiply colliding on the writeback port
    do_reset();
    for (int k = 0; k < 27; k++) begin
      if (k == 0) drive(1'b1, 1'b1, 1'b1, 7, 1'b0);
      else if (k == 16) drive(1'b1, 1'b0, 1'b0, 8, 1'b0);
      else idle_in();
      #1;
`ifndef MDU_ISSUE_BYPASS_EN
      chk("t3_iss", 32'(bus.iss_valid), 32'(k == 1 || k == 20));
      if (k >= 17 && k <= 19) chk("t3_stall_cnt", 32'(bus.count), 32'd1);
      if (k == 20) chk("t3_id", 32'(bus.iss_id), 32'd8);
      chk("t3_busy", 32'(bus.wb_slot_busy), 32'(k >= 21 && k <= 24));
`endif
      next_cyc();
    end

    // Fill the FIFO behind a blocked head
    do_reset();
    for (int k = 0; k < 28; k++) begin
      if (k == 0) drive(1'b1, 1'b1, 1'b0, 9, 1'b0);
      else if (k >= 16 && k <= 20) drive(1'b1, 1'b0, 1'b0, k, 1'b0);
      else idle_in();
      #1;
`ifndef MDU_ISSUE_BYPASS_EN
      if (k == 19) chk("t4_cnt19", 32'(bus.count), 32'd3);
      if (k == 20) chk("t4_cnt20", 32'(bus.count), 32'd4);
      if (k == 20) chk("t4_rdy20", 32'(bus.enq_ready), 32'd0);
      if (k == 20) chk("t4_id20", 32'(bus.iss_id), 32'd16);
      if (k == 21) chk("t4_cnt21", 32'(bus.count), 32'd3);
      if (k == 21) chk("t4_rdy21", 32'(bus.enq_ready), 32'd1);
`endif
      next_cyc();
    end

    // Flush with queued ops and a divide in flight
    do_reset();
    for (int k = 0; k < 27; k++) begin
      if (k == 0) drive(1'b1, 1'b1, 1'b0, 3, 1'b0);
      else if (k >= 16 && k <= 18) drive(1'b1, 1'b0, 1'b0, 24 + k, 1'b0);
      else if (k == 20) drive(1'b1, 1'b0, 1'b0, 50, 1'b1);
      else idle_in();
      #1;
`ifndef MDU_ISSUE_BYPASS_EN
      if (k == 19) chk("t5_cnt19", 32'(bus.count), 32'd3);
      if (k >= 20) chk("t5_iss", 32'(bus.iss_valid), 32'd0);
      if (k == 21) chk("t5_cnt21", 32'(bus.count), 32'd0);
      if (k >= 20 && k <= 23) chk("t5_busy", 32'(bus.wb_slot_busy), 32'(k == 21 || k == 22));
      if (k == 24) chk("t5_idle", 32'(bus.idle), 32'd1);
`endif
      next_cyc();
    end

`ifdef MDU_ISSUE_BYPASS_EN
    // Zero-latency issue from an empty FIFO
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 1'b0, 12, 1'b0); else idle_in();
      #1;
      chk("byp_iss", 32'(bus.iss_valid), 32'(k == 0));
      if (k == 0) chk("byp_id", 32'(bus.iss_id), 32'd12);
      if (k == 0) chk("byp_rdy", 32'(bus.enq_ready), 32'd1);
      if (k == 1) chk("byp_cnt", 32'(bus.count), 32'd0);
      chk("byp_busy", 32'(bus.wb_slot_busy), 32'(k == 3 || k == 4));
      next_cyc();
    end
`endif

    // Mixed traffic with a mid-stream flush, then reset while work is outstanding
    do_reset();
    for (int k = 0; k < 45; k++) begin
      drive(k % 3 != 2, k % 7 == 0, k[0], k, k == 25);
      next_cyc();
    end
    do_reset();
    check_reset("rst_mid");
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_issue_sched.md
Name: mdu_issue_sched

Overview:
- In-order issue scheduler that sits between the integer dispatch stage and the shared multiply/divide unit.
- Each MDU op writes back Hi, then Lo, on one shared PRF write port in two consecutive cycles; mul and div have different fixed pipeline latencies.
- The block buffers MDU ops in a small FIFO and issues the oldest op only when both of its writeback cycles are free.
- Result: mul/div writebacks never collide on the port.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- MUL_LAT, 3, cycles from issue to Hi writeback for multiply
- DIV_LAT, 20, cycles from issue to Hi writeback for divide (must be > MUL_LAT)
- ID_W, 6, ROB id width
- PRF_W, 6, physical register tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush  in  1  pipeline flush; drops queued ops
- enq_valid  in  1  new MDU op offered
- enq_ready  out  1  FIFO can accept
- enq_is_div  in  1  1=divide, 0=multiply
- enq_signed  in  1  signed variant
- enq_id  in  ID_W  ROB id
- enq_hi_prf  in  PRF_W  Hi destination tag
- enq_lo_prf  in  PRF_W  Lo destination tag
- iss_valid  out  1  op issued to MDU this cycle (operands read this cycle)
- iss_is_div, iss_signed, iss_id, iss_hi_prf, iss_lo_prf  out  1/1/ID_W/PRF_W/PRF_W  issued op fields
- wb_slot_busy  out  1  writeback port reserved for current cycle
- count  out  clog2(DEPTH)+1  valid FIFO entries
- idle  out  1  FIFO empty and no reservation outstanding

Behaviour:
- Reset (sync, active-high):
  - count=0, pointers=0, reservation vector resv all 0.
  - iss_valid=0, enq_ready=1, wb_slot_busy=0, idle=1.
  - Reset mid-operation abandons queued and in-flight tracking.
- FIFO:
  - Circular buffer; wr/rd pointers wrap modulo DEPTH.
  - enq_ready = (count < DEPTH); it does not credit a same-cycle dequeue.
  - Accept on enq_valid & enq_ready & !flush. Accepted entry becomes the head earliest the next cycle.
- Reservation vector resv[0..DIV_LAT+1]: resv[i]=1 means the wb port is claimed i cycles from now.
  - Head latency L = enq_is_div ? DIV_LAT : MUL_LAT.
  - can_issue = head valid & !resv[L] & !resv[L+1] & !flush.
  - iss_valid = can_issue (combinational from registered head and resv). iss_* = head fields; they are 0 when !iss_valid.
- Each cycle:
  - resv_next[i] = resv[i+1] | (iss_valid & (i+1==L | i+1==L+1)); top bit shifts in 0.
  - A dequeue advances the read pointer.
  - wb_slot_busy = resv[0].
  - idle = (count==0) & (resv==0).
- Ordering: strictly in order. A stalled head blocks younger ops even if those would fit.
- Simultaneous enq+issue: count unchanged, both pointers advance. Enq while full: ignored, no state change.
- Flush:
  - Next cycle count=0 and rd=wr.
  - iss_valid forced 0 in the flush cycle; a same-cycle enq is dropped.
  - resv is retained, because already-issued ops still write back.
- Two writeback cycles per op: an op issued at cycle t owns the port at t+L (Hi) and t+L+1 (Lo).
- Arithmetic: count in clog2(DEPTH)+1 bits; no overflow by construction.

Optional Feature:
- Macro MDU_ISSUE_BYPASS_EN.
- Defined: when the FIFO is empty, not flushing, and enq_valid with a conflict-free reservation for the incoming op, the op issues in the same cycle directly from enq_* without being written to the FIFO (zero-cycle issue latency). enq_ready is still asserted.
- Undefined: every op is written to the FIFO first; minimum enq-to-issue latency is 1 cycle.

Test Plan:
- Single mul: after reset, enq mul id=5 at cycle 0 -> iss_valid at cycle 1 (bypass off); wb_slot_busy=1 at cycles 4,5 only; idle=1 from cycle 6.
- Back-to-back muls: enq mul A at cycle 0 and mul B at cycle 1 -> A issues cycle 1 (wb 4,5); B stalls at cycle 2 and issues cycle 3 (wb 6,7).
- Div/mul collision: enq div at 0 (issues 1, wb 21,22), enq mul at 16 -> mul head at 17; stalled cycles 17–19; issues cycle 20 with wb 23,24.
- Full FIFO: block issue with an outstanding div, enq 4 ops on consecutive cycles -> count=4 and enq_ready=0; a 5th enq is ignored; enq_ready returns 1 the cycle after the first dequeue.
- Flush: 3 ops queued and one div in flight, flush=1 with enq_valid=1 -> next cycle count=0; the enq is dropped; iss_valid=0 in the flush cycle; the div's wb_slot_busy pulses still occur.
- Bypass (MDU_ISSUE_BYPASS_EN): empty FIFO, enq mul at cycle 0 -> iss_valid at cycle 0 with wb at 3,4; count stays 0.
